// File: rtl/ltc2668_pkg.sv
// Shared types for the LTC2668 channel sequencer: DAC commands, the 32-bit frame
// layout, FSM states and the channel-index wrap helper.
package ltc2668_pkg;

    localparam int FRAME_BYTES = 4;
    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 16;

    typedef enum logic [3:0] {
        WR_N       = 4'h0,
        WR_UPD_ALL = 4'h2,
        WR_UPD_N   = 4'h3
    } ltc_cmd_e;

    typedef struct packed {
        logic [7:0]        pad;
        ltc_cmd_e          cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ltc_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    // Channel after ch, wrapping at n_ch (n_ch need not be a power of two).
    function automatic logic [ADDR_W-1:0] next_ch(input logic [ADDR_W-1:0] ch, input int n_ch);
        logic [ADDR_W:0] nxt;
        nxt = {1'b0, ch} + {{ADDR_W{1'b0}}, 1'b1};
        if (int'(nxt) >= n_ch) nxt = '0;
        return nxt[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/ltc2668_dirty_picker.sv
// Rotating-priority encoder: first dirty channel at or after ptr, wrapping at N_CH.
module ltc2668_dirty_picker
    import ltc2668_pkg::*;
#(
    parameter int N_CH = 16
) (
    input  logic [N_CH-1:0]   dirty,
    input  logic [ADDR_W-1:0] ptr,
    output logic              found,
    output logic [ADDR_W-1:0] idx,
    output logic              only_one
);

    logic [2*N_CH-1:0] doubled;
    logic [N_CH-1:0]   rotated;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W:0]   sum;

    // rotated[i] holds the dirty bit of channel (ptr + i) mod N_CH.
    assign doubled = {dirty, dirty} >> ptr;
    assign rotated = doubled[N_CH-1:0];

    always_comb begin
        offset = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rotated[i]) offset = ADDR_W'(i);
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, offset};
        if (int'(sum) >= N_CH) sum = sum - (ADDR_W + 1)'(N_CH);
    end

    assign found    = |dirty;
    assign idx      = sum[ADDR_W-1:0];
    assign only_one = found && ((dirty & (dirty - N_CH'(1))) == '0);

endmodule

// File: rtl/ltc2668_channel_sequencer.sv
// LTC2668 command sequencer: per-channel shadow codes, round-robin frame issue to a
// byte-wide SPI master. Define LTC2668_ECHO_CHECK_EN to check the SDO echo of each frame.
module ltc2668_channel_sequencer
    import ltc2668_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int CODE_W = 16
) (
    input  logic              i_FPGA_clk,
    input  logic              i_FPGA_rst,
    input  logic              i_ch_valid,
    input  logic [3:0]        i_ch_addr,
    input  logic [CODE_W-1:0] i_ch_code,
    output logic              o_ch_ready,
    output logic              o_addr_err,
    input  logic              i_batch,
    output logic [7:0]        o_MOSI,
    output logic              o_MOSIdv,
    output logic [4:0]        o_MOSI_count,
    input  logic              i_MOSI_ready,
    input  logic [7:0]        i_MISO,
    input  logic              i_MISOdv,
    output logic              o_busy,
    output logic [15:0]       o_frames,
    output logic              o_echo_err,
    input  logic              i_echo_clr,
    output seq_state_e        o_dbg_state
);

    // Handshakes: a write transfers on any cycle with i_ch_valid && o_ch_ready (ready only
    // drops in reset); o_MOSIdv is a one-cycle strobe issued only while i_MOSI_ready is high.
    seq_state_e        state, next_state;
    logic [DATA_W-1:0] shadow [N_CH];
    logic [N_CH-1:0]   dirty;
    logic [ADDR_W-1:0] rr_ptr;
    ltc_frame_t        frame_q;
    logic [1:0]        byte_cnt;
    logic              ready_q;

    logic              wr_acc, wr_ok, is_last, byte_go, frame_end;
    logic [DATA_W-1:0] code_lj, pick_data;
    logic              pick_found, pick_only;
    logic [ADDR_W-1:0] pick_idx;

    assign o_ch_ready   = ready_q;
    assign wr_acc       = i_ch_valid & ready_q;
    assign wr_ok        = wr_acc & (int'(i_ch_addr) < N_CH);
    assign code_lj      = DATA_W'(i_ch_code) << (DATA_W - CODE_W);
    assign is_last      = pick_only & ~wr_acc;
    assign o_MOSI_count = 5'(FRAME_BYTES);
    assign o_dbg_state  = state;

    ltc2668_dirty_picker #(.N_CH(N_CH)) u_picker (
        .dirty    (dirty),
        .ptr      (rr_ptr),
        .found    (pick_found),
        .idx      (pick_idx),
        .only_one (pick_only)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (pick_idx == ADDR_W'(i)) pick_data = shadow[i];
        end
    end

    always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
        if (i_FPGA_rst) begin
            ready_q    <= 1'b0;
            o_addr_err <= 1'b0;
            dirty      <= '0;
            for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
        end else begin
            ready_q    <= 1'b1;
            o_addr_err <= wr_acc & ~wr_ok;
            for (int i = 0; i < N_CH; i++) begin
                // A write to the channel being loaded keeps it dirty so it is resent.
                if (wr_ok && i_ch_addr == ADDR_W'(i)) begin
                    shadow[i] <= code_lj;
                    dirty[i]  <= 1'b1;
                end else if (state == ST_LOAD && pick_found && pick_idx == ADDR_W'(i)) begin
                    dirty[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
        if (i_FPGA_rst) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
        if (i_FPGA_rst) begin
            frame_q  <= '0;
            byte_cnt <= '0;
            rr_ptr   <= '0;
            o_frames <= '0;
        end else begin
            if (state == ST_LOAD) begin
                frame_q.pad  <= 8'h00;
                frame_q.cmd  <= !i_batch ? WR_UPD_N : (is_last ? WR_UPD_ALL : WR_N);
                frame_q.addr <= pick_idx;
                frame_q.data <= pick_data;
                byte_cnt     <= '0;
                rr_ptr       <= next_ch(pick_idx, N_CH);
            end
            if (byte_go)   byte_cnt <= byte_cnt + 2'd1;
            if (frame_end) o_frames <= o_frames + 16'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (|dirty || wr_ok) next_state = ST_LOAD;
            ST_LOAD: next_state = ST_SEND;
            ST_SEND: if (i_MOSI_ready) next_state = (byte_cnt == 2'd3) ? ST_DONE : ST_WAIT;
            ST_WAIT: next_state = ST_SEND;
            ST_DONE: if (i_MOSI_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_MOSIdv  = 1'b0;
        o_MOSI    = 8'h00;
        byte_go   = 1'b0;
        frame_end = 1'b0;
        o_busy    = (state != ST_IDLE);
        case (state)
            ST_SEND: begin
                if (i_MOSI_ready) begin
                    o_MOSIdv = 1'b1;
                    byte_go  = 1'b1;
                    case (byte_cnt)
                        2'd0:    o_MOSI = frame_q.pad;
                        2'd1:    o_MOSI = {frame_q.cmd, frame_q.addr};
                        2'd2:    o_MOSI = frame_q.data[15:8];
                        default: o_MOSI = frame_q.data[7:0];
                    endcase
                end
            end
            ST_DONE: frame_end = i_MOSI_ready;
            default: ;
        endcase
    end

`ifdef LTC2668_ECHO_CHECK_EN
    logic [31:0] miso_sr, miso_word, prev_tx;
    logic        prev_valid, echo_err_q;

    // The last echo byte may arrive in the same cycle the frame closes.
    assign miso_word  = i_MISOdv ? {miso_sr[23:0], i_MISO} : miso_sr;
    assign o_echo_err = echo_err_q;

    always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
        if (i_FPGA_rst) begin
            miso_sr    <= '0;
            prev_tx    <= '0;
            prev_valid <= 1'b0;
            echo_err_q <= 1'b0;
        end else begin
            if (i_MISOdv) miso_sr <= {miso_sr[23:0], i_MISO};
            if (frame_end) begin
                prev_tx    <= frame_q;
                prev_valid <= 1'b1;
            end
            if (frame_end && prev_valid && miso_word != prev_tx) echo_err_q <= 1'b1;
            else if (i_echo_clr)                                 echo_err_q <= 1'b0;
        end
    end
`else
    logic unused_echo;
    assign unused_echo = &{1'b0, i_MISO, i_MISOdv, i_echo_clr};
    assign o_echo_err  = 1'b0;
`endif

endmodule

// File: doc/ltc2668_channel_sequencer.md
# ltc2668_channel_sequencer

Parametrised multi-channel command sequencer for the LTC2668 DAC, sitting between the data path and the byte-wide SPI master (SPIMasterCS). It holds a shadow code per channel with a dirty bit, picks dirty channels round-robin, and emits 32-bit LTC2668 frames as four MOSI bytes per chip-select. It supports an immediate-update mode and a batched mode that ends with a single update-all. Optionally it checks the DAC's SDO echo of each previous frame.

## Interface
- N_CH, 16: channel count, 1..16; address width is 4.
- CODE_W, 16: input code width, ≤16; left-justified into the 16-bit data field, LSBs zero.
- i_FPGA_clk  in  1  system clock.
- i_FPGA_rst  in  1  asynchronous, active-high reset.
- i_ch_valid  in  1  channel write request.
- i_ch_addr  in  4  target channel.
- i_ch_code  in  CODE_W  DAC code.
- o_ch_ready  out  1  always 1 outside reset; a write is accepted on valid&ready.
- o_addr_err  out  1  one-cycle pulse when an accepted i_ch_addr ≥ N_CH.
- i_batch  in  1  0 = immediate mode, 1 = batched mode; sampled at each frame load.
- o_MOSI  out  8  byte to the SPI master.
- o_MOSIdv  out  1  one-cycle byte strobe.
- o_MOSI_count  out  5  bytes per CS; constant 4.
- i_MOSI_ready  in  1  SPI master ready for the next byte.
- i_MISO  in  8  received byte.
- i_MISOdv  in  1  received-byte strobe.
- o_busy  out  1  a frame is in flight.
- o_frames  out  16  count of frames sent; wraps.
- o_echo_err  out  1  sticky echo-mismatch flag.
- i_echo_clr  in  1  clears o_echo_err.

## Operation
- **Frame layout**, sent MSB byte first:
  - byte 0: 0x00
  - byte 1: {cmd[3:0], addr[3:0]}
  - byte 2: data[15:8]
  - byte 3: data[7:0]
- **Commands:**
  - Immediate mode uses 0x3 (write n, update n).
  - Batched mode uses 0x0 (write n) for every frame except the last dirty channel, which uses 0x2 (write n, update all).
  - A frame is "last" when, at LOAD, no other dirty bit is set and no write is being accepted in that same cycle.
- **Writes:**
  - An accepted write stores the code in the shadow register and sets the channel's dirty bit.
  - If addr ≥ N_CH, the write is dropped and o_addr_err pulses.
- **FSM:**
  - IDLE: go to LOAD when any dirty bit is set.
  - LOAD: pick the channel, latch the frame from the shadow register, clear that dirty bit, go to SEND.
  - SEND: when i_MOSI_ready, assert o_MOSIdv with the current byte. Go to WAIT, or to DONE after byte 3.
  - WAIT: wait one cycle for ready to drop, then return to SEND.
  - DONE: increment o_frames, wait for i_MOSI_ready, return to IDLE.
- **Round-robin pick:** search for the first dirty channel at or above (last sent + 1) mod N_CH, wrapping.
- **Write to an in-flight channel:** the latched frame is unaffected. The dirty bit is set again, so the channel is resent later.
- **Simultaneous write and LOAD-clear on the same channel:** the set wins.

## Timing
- **Reset values:**
  - o_MOSI = 0, o_MOSIdv = 0, o_busy = 0, o_frames = 0, o_echo_err = 0, o_addr_err = 0.
  - o_ch_ready = 0 during reset, 1 after.
  - o_MOSI_count = 4 at all times.
- Reset clears all shadow registers, dirty bits and the round-robin pointer, and returns the FSM to IDLE. Reset mid-frame abandons the frame; the SPI master is reset by the same signal.
- **Latency:**
  - A write accepted in cycle t makes its dirty bit visible at t+1.
  - With the FSM idle, LOAD occurs at t+1 and the first o_MOSIdv no earlier than t+2.
- o_busy is high from LOAD through DONE.
- o_MOSIdv never asserts while i_MOSI_ready is low, and never asserts on consecutive cycles.

## Configuration
- **LTC2668_ECHO_CHECK_EN defined:**
  - Capture the four i_MISOdv bytes of each frame into a 32-bit word.
  - After frame k completes (k ≥ 2 since reset), compare that word with the frame k−1 transmitted word. On mismatch, set o_echo_err.
  - i_echo_clr clears o_echo_err. If a clear and a set occur in the same cycle, the set wins.
- **Undefined:** i_MISO and i_MISOdv are ignored and o_echo_err is tied to 0.

## Structure
- **Package ltc2668_pkg:**
  - command enum: WR_N = 0x0, WR_UPD_ALL = 0x2, WR_UPD_N = 0x3
  - frame struct {pad, cmd, addr, data}
  - FRAME_BYTES = 4
  - FSM state enum
- **Sub-module ltc2668_dirty_picker:** a combinational rotating-priority encoder.
  - Inputs: dirty vector, pointer.
  - Outputs: found flag, index, "only one set" flag.

## Test plan
- **Immediate write:** immediate mode, write ch 5 = 0xABCD, SPI model holds ready high → exactly one frame, bytes 0x00, 0x35, 0xAB, 0xCD; o_frames = 1.
- **Batched frames:** batched mode, write ch 2, 7 and 9 in consecutive cycles → frames 0x02, 0x07 and 0x29 (in that order, with their codes), then IDLE.
- **Round-robin with re-dirty:**
  - Start: pointer after ch 9; ch 1 and ch 10 dirty → ch 10 is sent before ch 1.
  - Rewrite ch 10 while its frame is in flight → ch 10 is sent again carrying the new code.
- **Bad address:** write ch 12 with N_CH = 12 → o_addr_err pulses once and no frame is sent. CODE_W = 12, code 0xFFF → data field 0xFFF0.
- **Reset mid-frame:** assert reset after byte 1 → all outputs at reset values, no further o_MOSIdv, shadow registers read back 0 after release.
- **Echo check** (macro on):
  - MISO returns the previous frame → o_echo_err stays 0.
  - Corrupt one echoed bit → o_echo_err sets after that frame.
  - i_echo_clr → o_echo_err returns to 0.
